// File: rtl/dino_audio_pkg.sv
// Shared types and constants for the dino game audio path: state codes,
// counter widths and the default note pitches/durations.
package dino_audio_pkg;

    localparam int HP_W = 16;
    localparam int TK_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_JUMP0 = 3'd1,
        ST_JUMP1 = 3'd2,
        ST_OVER0 = 3'd3,
        ST_OVER1 = 3'd4,
        ST_OVER2 = 3'd5
    } sfx_state_t;

    localparam int unsigned DEF_JUMP_HP0   = 12588;
    localparam int unsigned DEF_JUMP_HP1   = 8392;
    localparam int unsigned DEF_OVER_HP0   = 16784;
    localparam int unsigned DEF_OVER_HP1   = 25175;
    localparam int unsigned DEF_OVER_HP2   = 50350;
    localparam int unsigned DEF_JUMP_TICKS = 4;
    localparam int unsigned DEF_OVER_TICKS = 12;

    // Jump pulses are locked out while the game-over melody plays.
    function automatic logic is_over_state(input sfx_state_t s);
        return (s == ST_OVER0) || (s == ST_OVER1) || (s == ST_OVER2);
    endfunction

    function automatic logic is_legal_state(input sfx_state_t s);
        return (s == ST_IDLE)  || (s == ST_JUMP0) || (s == ST_JUMP1) ||
               (s == ST_OVER0) || (s == ST_OVER1) || (s == ST_OVER2);
    endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: toggles the output every half_period clocks while
// enabled; clear restarts the wave low with the counter at zero.
module sfx_tone_gen
    import dino_audio_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    input  logic [HP_W-1:0] half_period,
    output logic            square
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            sq_q, sq_d;

    always_comb begin
        cnt_d = cnt_q;
        sq_d  = sq_q;
        if (clear || !enable) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (cnt_q == (half_period - 16'd1)) begin
            cnt_d = '0;
            sq_d  = ~sq_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
        end
    end

    assign square = sq_q;

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays the jump chirp and the game-over melody as
// square-wave notes timed in 60 Hz game ticks.
module sfx_sequencer
    import dino_audio_pkg::*;
#(
    parameter int unsigned JUMP_HP0   = DEF_JUMP_HP0,
    parameter int unsigned JUMP_HP1   = DEF_JUMP_HP1,
    parameter int unsigned OVER_HP0   = DEF_OVER_HP0,
    parameter int unsigned OVER_HP1   = DEF_OVER_HP1,
    parameter int unsigned OVER_HP2   = DEF_OVER_HP2,
    parameter int unsigned JUMP_TICKS = DEF_JUMP_TICKS,
    parameter int unsigned OVER_TICKS = DEF_OVER_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick_60hz,
    input  logic       i_jump_pulse,
    input  logic       i_game_over_pulse,
    output logic       o_sound,
    output logic       o_busy,
    output logic [2:0] o_state
);

    if (JUMP_HP0 < 2 || JUMP_HP0 > 65535 || JUMP_HP1 < 2 || JUMP_HP1 > 65535 ||
        OVER_HP0 < 2 || OVER_HP0 > 65535 || OVER_HP1 < 2 || OVER_HP1 > 65535 ||
        OVER_HP2 < 2 || OVER_HP2 > 65535) begin : g_bad_half_period
        $error("sfx_sequencer: every half-period must lie in 2..65535");
    end

    if (JUMP_TICKS < 1 || JUMP_TICKS > 15 ||
        OVER_TICKS < 1 || OVER_TICKS > 15) begin : g_bad_ticks
        $error("sfx_sequencer: note durations must lie in 1..15 ticks");
    end

    localparam logic [TK_W-1:0] JUMP_TK = TK_W'(JUMP_TICKS);
    localparam logic [TK_W-1:0] OVER_TK = TK_W'(OVER_TICKS);

    sfx_state_t      state_q, state_d;
    logic [TK_W-1:0] tick_q, tick_d;
    logic            tone_clear;
    logic [HP_W-1:0] half_period;

    // Events outrank tick-driven advancement, so a fresh note always gets
    // its full tick load even when a tick lands on the same cycle.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        tone_clear = 1'b0;
        if (!is_legal_state(state_q)) begin
            state_d    = ST_IDLE;
            tick_d     = '0;
            tone_clear = 1'b1;
        end else if (i_game_over_pulse) begin
            state_d    = ST_OVER0;
            tick_d     = OVER_TK;
            tone_clear = 1'b1;
        end else if (i_jump_pulse && !is_over_state(state_q)) begin
            state_d    = ST_JUMP0;
            tick_d     = JUMP_TK;
            tone_clear = 1'b1;
        end else if (state_q != ST_IDLE && i_tick_60hz) begin
            if (tick_q <= TK_W'(1)) begin
                tone_clear = 1'b1;
                case (state_q)
                    ST_JUMP0: begin
                        state_d = ST_JUMP1;
                        tick_d  = JUMP_TK;
                    end
                    ST_OVER0: begin
                        state_d = ST_OVER1;
                        tick_d  = OVER_TK;
                    end
                    ST_OVER1: begin
                        state_d = ST_OVER2;
                        tick_d  = OVER_TK;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end
                endcase
            end else begin
                tick_d = tick_q - TK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        half_period = HP_W'(JUMP_HP0);
        case (state_q)
            ST_JUMP1: half_period = HP_W'(JUMP_HP1);
            ST_OVER0: half_period = HP_W'(OVER_HP0);
            ST_OVER1: half_period = HP_W'(OVER_HP1);
            ST_OVER2: half_period = HP_W'(OVER_HP2);
            default:  half_period = HP_W'(JUMP_HP0);
        endcase
    end

    sfx_tone_gen u_tone (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (tone_clear),
        .enable      (state_q != ST_IDLE),
        .half_period (half_period),
        .square      (o_sound)
    );

    assign o_busy  = (state_q != ST_IDLE);
    assign o_state = state_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer using small test pitches/durations
// and a note-level reference model of the sound effects.
module tb_sfx_sequencer;

    localparam int JHP0 = 4;
    localparam int JHP1 = 3;
    localparam int OHP0 = 5;
    localparam int OHP1 = 6;
    localparam int OHP2 = 7;
    localparam int JT   = 2;
    localparam int OT   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_tick_60hz;
    logic       i_jump_pulse;
    logic       i_game_over_pulse;
    logic       o_sound;
    logic       o_busy;
    logic [2:0] o_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit tickEn   = 1'b0;

    // Reference: which note is playing, ticks left in it, clocks since it began.
    int mState = 0;
    int mLeft  = 0;
    int mK     = 0;

    sfx_sequencer #(
        .JUMP_HP0   (JHP0),
        .JUMP_HP1   (JHP1),
        .OVER_HP0   (OHP0),
        .OVER_HP1   (OHP1),
        .OVER_HP2   (OHP2),
        .JUMP_TICKS (JT),
        .OVER_TICKS (OT)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_tick_60hz       (i_tick_60hz),
        .i_jump_pulse      (i_jump_pulse),
        .i_game_over_pulse (i_game_over_pulse),
        .o_sound           (o_sound),
        .o_busy            (o_busy),
        .o_state           (o_state)
    );

    always #5 clk = ~clk;

    function automatic int hpOf(input int s);
        case (s)
            1: return JHP0;
            2: return JHP1;
            3: return OHP0;
            4: return OHP1;
            default: return OHP2;
        endcase
    endfunction

    // Melody order: jump 0 -> jump 1 -> silence, over 0 -> 1 -> 2 -> silence.
    function automatic int nextOf(input int s);
        case (s)
            1: return 2;
            3: return 4;
            4: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int ticksOf(input int s);
        if (s == 1 || s == 2) return JT;
        if (s >= 3) return OT;
        return 0;
    endfunction

    function automatic logic [4:0] expVec();
        logic snd;
        snd = (mState == 0) ? 1'b0 : 1'(((mK / hpOf(mState)) % 2));
        return {3'(mState), (mState != 0), snd};
    endfunction

    function automatic bit autoTick();
        return tickEn && ((cyc % 100) == 99);
    endfunction

    task automatic modelStep(input bit r, input bit g, input bit j, input bit t);
        if (!r) begin
            mState = 0; mLeft = 0; mK = 0;
        end else if (g) begin
            mState = 3; mLeft = OT; mK = 0;
        end else if (j && mState <= 2) begin
            mState = 1; mLeft = JT; mK = 0;
        end else if (mState != 0 && t) begin
            if (mLeft == 1) begin
                mState = nextOf(mState); mLeft = ticksOf(mState); mK = 0;
            end else begin
                mLeft = mLeft - 1; mK = mK + 1;
            end
        end else if (mState != 0) begin
            mK = mK + 1;
        end
    endtask

    // One clock: inputs held across the rising edge, released 1 time unit after.
    task automatic applyStimulus(input bit r, input bit g, input bit j, input bit t);
        rst_n = r; i_game_over_pulse = g; i_jump_pulse = j; i_tick_60hz = t;
        @(posedge clk);
        cyc = cyc + 1;
        modelStep(r, g, j, t);
        #1;
        rst_n = 1'b1; i_game_over_pulse = 1'b0; i_jump_pulse = 1'b0; i_tick_60hz = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] want;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({o_state, o_busy, o_sound} !== 5'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", cyc, {o_state, o_busy, o_sound}, 5'b0);
            end
        end
        tickEn = 1'b1;
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, autoTick());
            want = expVec();
            checks++;
            if ({o_state, o_busy, o_sound} !== want || want !== 5'b0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, {o_state, o_busy, o_sound}, 5'b0);
            end
        end
    endtask

    task automatic test_jump_no_ticks();
        logic [4:0] want;
        logic       prev;
        tickEn = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (o_state !== 3'd1 || o_busy !== 1'b1 || o_sound !== 1'b0) begin
            failures++;
            $display("FAIL jump_entry got state=%0d busy=%0b sound=%0b want state=1 busy=1 sound=0",
                     o_state, o_busy, o_sound);
        end
        prev = o_sound;
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            want = expVec();
            checks++;
            if ({o_state, o_busy, o_sound} !== want) begin
                failures++;
                $display("FAIL jump_tone cyc=%0d got=%b want=%b", cyc, {o_state, o_busy, o_sound}, want);
            end
            // The wave must flip exactly on every 4th clock of the note.
            checks++;
            if ((o_sound !== prev) !== ((i % 4) == 0)) begin
                failures++;
                $display("FAIL jump_toggle i=%0d got sound=%0b prev=%0b want toggle=%0b", i, o_sound, prev, (i % 4) == 0);
            end
            prev = o_sound;
        end
    endtask

    task automatic test_jump_ticks();
        logic [4:0] want;
        tickEn = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, autoTick());
        for (int i = 0; i < 450; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, autoTick());
            want = expVec();
            checks++;
            if ({o_state, o_busy, o_sound} !== want) begin
                failures++;
                $display("FAIL jump_seq cyc=%0d got=%b want=%b", cyc, {o_state, o_busy, o_sound}, want);
            end
        end
        checks++;
        if (o_state !== 3'd0 || o_busy !== 1'b0 || o_sound !== 1'b0) begin
            failures++;
            $display("FAIL jump_done got state=%0d busy=%0b sound=%0b want 0/0/0", o_state, o_busy, o_sound);
        end
    endtask

    task automatic test_game_over_priority();
        logic [4:0] want;
        bit         jumped;
        tickEn = 1'b1;
        jumped = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, autoTick());
        checks++;
        if (o_state !== 3'd3) begin
            failures++;
            $display("FAIL over_priority got state=%0d want state=3", o_state);
        end
        for (int i = 0; i < 1100; i++) begin
            if (!jumped && mState == 4 && mK == 20) begin
                applyStimulus(1'b1, 1'b0, 1'b1, autoTick());
                jumped = 1'b1;
                checks++;
                if (o_state !== 3'd4) begin
                    failures++;
                    $display("FAIL over_jump_ignored got state=%0d want state=4", o_state);
                end
            end else begin
                applyStimulus(1'b1, 1'b0, 1'b0, autoTick());
            end
            want = expVec();
            checks++;
            if ({o_state, o_busy, o_sound} !== want) begin
                failures++;
                $display("FAIL over_seq cyc=%0d got=%b want=%b", cyc, {o_state, o_busy, o_sound}, want);
            end
        end
        checks++;
        if (!jumped || o_state !== 3'd0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL over_done got state=%0d busy=%0b jumped=%0b want state=0 busy=0 jumped=1",
                     o_state, o_busy, jumped);
        end
    endtask

    task automatic test_restart();
        logic [4:0] want;
        int         reached;
        tickEn = 1'b1;
        reached = 0;
        applyStimulus(1'b1, 1'b0, 1'b1, autoTick());
        for (int i = 0; i < 400 && reached == 0; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, autoTick());
            if (mState == 2 && mK == 10) reached = 1;
        end
        checks++;
        if (reached == 0 || o_state !== 3'd2) begin
            failures++;
            $display("FAIL restart_reach got state=%0d reached=%0d want state=2 reached=1", o_state, reached);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, autoTick());
        checks++;
        if (o_state !== 3'd1 || o_sound !== 1'b0) begin
            failures++;
            $display("FAIL restart_entry got state=%0d sound=%0b want state=1 sound=0", o_state, o_sound);
        end
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, autoTick());
            want = expVec();
            checks++;
            if ({o_state, o_busy, o_sound} !== want) begin
                failures++;
                $display("FAIL restart_seq cyc=%0d got=%b want=%b", cyc, {o_state, o_busy, o_sound}, want);
            end
        end
    endtask

    task automatic test_reset_mid_note();
        logic [4:0] want;
        tickEn = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, autoTick());
        for (int i = 0; i < 600 && !(mState == 4 && mK == 17); i++)
            applyStimulus(1'b1, 1'b0, 1'b0, autoTick());
        applyStimulus(1'b0, 1'b0, 1'b0, autoTick());
        checks++;
        if (o_state !== 3'd0 || o_sound !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got state=%0d busy=%0b sound=%0b want 0/0/0", o_state, o_busy, o_sound);
        end
        // Line a jump pulse up with a tick: the new note keeps its full duration.
        for (int i = 0; i < 200 && !autoTick(); i++)
            applyStimulus(1'b1, 1'b0, 1'b0, autoTick());
        applyStimulus(1'b1, 1'b0, 1'b1, autoTick());
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, autoTick());
            want = expVec();
            checks++;
            if ({o_state, o_busy, o_sound} !== want) begin
                failures++;
                $display("FAIL collide_seq cyc=%0d got=%b want=%b", cyc, {o_state, o_busy, o_sound}, want);
            end
        end
        checks++;
        if (o_state !== 3'd1) begin
            failures++;
            $display("FAIL collide_full_note got state=%0d want state=1", o_state);
        end
    endtask

    task automatic test_random();
        logic [4:0] want;
        bit         r, g, j, t;
        tickEn = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 499) != 0);
            g = ($urandom_range(0, 299) == 0);
            j = ($urandom_range(0, 59) == 0);
            t = ($urandom_range(0, 24) == 0);
            applyStimulus(r, g, j, t);
            want = expVec();
            checks++;
            if ({o_state, o_busy, o_sound} !== want) begin
                failures++;
                $display("FAIL random cyc=%0d r=%0b g=%0b j=%0b t=%0b got=%b want=%b",
                         cyc, r, g, j, t, {o_state, o_busy, o_sound}, want);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_tick_60hz = 1'b0;
        i_jump_pulse = 1'b0;
        i_game_over_pulse = 1'b0;
        test_reset();
        test_jump_no_ticks();
        test_jump_ticks();
        test_game_over_priority();
        test_restart();
        test_reset_mid_note();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
